ahbl_sram_wide: RTL
===================

# ahbl_sram_wide

Parametrised AHB-Lite slave wrapping an inferred, byte-enabled, single-port synchronous SRAM. Successor to the fixed 32-bit fabric-SRAM interface. Adds:
- configurable data width, depth and wait states;
- a delayed-write buffer with read forwarding;
- an ERROR response for out-of-range addresses and illegal sizes.

It sits on the system AHB-Lite bus matrix as a memory slave.

## Interface
Parameters:
- DATA_WIDTH, 32 — bus and RAM word width; legal values 32 or 64.
- DEPTH, 1024 — RAM words; power of two, ≥ 16.
- ADDR_WIDTH, 20 — width of HADDR used for decode.
- WAIT_STATES, 0 — extra HREADYOUT-low cycles per read or write data phase; range 0–3.

Ports:
- HCLK  in  1  — clock; all logic on the rising edge.
- HRESET  in  1  — synchronous, active-high reset.
- HSEL  in  1  — slave select.
- HREADYIN  in  1  — bus-wide ready; qualifies the address phase.
- HADDR  in  ADDR_WIDTH  — byte address.
- HTRANS  in  2  — IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HBURST  in  3  — accepted but ignored; each beat is decoded independently.
- HSIZE  in  3  — transfer size; legal values are ≤ log2(DATA_WIDTH/8).
- HWRITE  in  1  — 1 = write.
- HWDATA  in  DATA_WIDTH  — write data, valid in the data phase.
- HRDATA  out  DATA_WIDTH  — read data.
- HREADYOUT  out  1  — slave ready.
- HRESP  out  2  — 00 OKAY, 01 ERROR.

## Operation
- **Valid transfer:** HSEL & HREADYIN & HTRANS[1]. IDLE and BUSY beats get a zero-wait OKAY response and cause no RAM access.
- **Address-phase capture:** word address, byte lanes, HWRITE and error flag are registered.
- **Byte lanes:** derived from HSIZE and the low HADDR bits, little-endian.
  - Byte → 1 lane; halfword → 2 lanes; word → 4 lanes; dword → all lanes.
  - Unaligned low address bits are masked to the size boundary.
- **Error conditions:** HADDR ≥ DEPTH*DATA_WIDTH/8, or illegal HSIZE.
- **FSM states:** IDLE, WAIT, ERR1, ERR2.
  - IDLE → ERR1 on an erroring transfer. ERR1 drives HREADYOUT=0, HRESP=01.
  - ERR1 → ERR2 unconditionally. ERR2 drives HREADYOUT=1, HRESP=01.
  - ERR2 → IDLE, or back to ERR1/WAIT if a new valid transfer arrives in ERR2.
  - An erroring transfer never touches the RAM.
  - IDLE → WAIT on a valid transfer when WAIT_STATES>0. A counter loads WAIT_STATES and HREADYOUT stays 0 until it reaches 0.
  - WAIT → IDLE when the counter expires, unless a new transfer is captured.
- **Writes:** the address is held in the write buffer (addr, lanes, pending). HWDATA is latched into the buffer at the end of the data phase, i.e. the cycle with HREADYOUT=1.
- **Buffer commit:** the buffer writes to RAM in the next cycle with no RAM read, or at the latest the cycle after. A read never stalls for a write.
- **Read forwarding:** if a read hits a pending-buffer address, lanes present in the buffer replace the corresponding RAM bytes in HRDATA.
- **HRDATA retention:** holds its last value when no read completes.

## Timing
- **Reset values:** HREADYOUT=1, HRESP=00, HRDATA=0, FSM=IDLE, write buffer empty, wait counter=0.
- **Reset mid-transfer:** the pending write is discarded and the response is aborted.
- **Read latency:** RAM address is applied in the address-phase cycle; data is valid in the data phase.
  - WAIT_STATES=0: HRDATA valid 1 cycle after the address phase.
  - Otherwise: HRDATA is valid on the cycle HREADYOUT returns to 1, i.e. 1+WAIT_STATES cycles after the address phase.
- **Throughput:** back-to-back NONSEQ/SEQ at WAIT_STATES=0 sustains one beat per cycle, including read-after-write to the same address.
- **Error response:** always two cycles (ERR1, ERR2), independent of WAIT_STATES.
- **HREADYIN=0:** with HSEL=1, the address phase is ignored. Slave state is unchanged except for completion of its own data phase.
- **Buffer collision:** a write address phase while the buffer is still pending forces a commit in that same cycle. The RAM port is free because a write address phase performs no read.

## Structure
- **Package ahbl_sram_pkg:** HTRANS/HRESP encodings, FSM state enum, and a lane-mask function (HSIZE, addr_lsb, DATA_WIDTH).
- **Sub-module ahbl_sram_mem:** single-port RAM, DEPTH × DATA_WIDTH, per-byte write enables, registered read. Vendor-inferable.
- **Top level:** holds the FSM, wait counter, write buffer and forwarding mux.

## Test plan
- **Word write/read, WAIT_STATES=0, DATA_WIDTH=32:** write 0xDEADBEEF @0x10, then read @0x10 back-to-back → HRDATA=0xDEADBEEF one cycle after the read address phase, via forwarding, with no wait cycles.
- **Byte lanes:** write word 0x11223344 @0x20, then byte 0xAA @0x21 → word read returns 0x1122AA44. Halfword 0xBEEF @0x22 → 0xBEEFAA44.
- **Out of range, DEPTH=1024, 32-bit:** read @0x1000 → HREADYOUT 0 then 1 with HRESP=01 on both cycles; a following legal read gets OKAY.
- **WAIT_STATES=2, incr4 read burst:** each beat holds HREADYOUT=0 for exactly 2 cycles; data matches previously written values 0,1,2,3.
- **DATA_WIDTH=64:** HSIZE=011 write 0x0123456789ABCDEF @0x8 → readback matches. HSIZE=100 → ERROR and RAM unchanged.
- **Reset mid-write:** assert HRESET in the write data phase → HREADYOUT=1, HRESP=00 next cycle; the target address keeps its old contents.

Source files
------------

// File: rtl/ahbl_sram_pkg.sv
// Shared encodings, FSM state type and byte-lane helper for the AHB-Lite SRAM slave.
package ahbl_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Little-endian lane mask; low address bits are aligned down to the transfer size.
    function automatic logic [7:0] lane_mask(input logic [2:0] size,
                                             input logic [2:0] addr_lsb,
                                             input int unsigned data_width);
        logic [3:0]  nbytes;
        logic [2:0]  off;
        logic [15:0] m;
        nbytes = 4'(1) << size;
        off    = addr_lsb & 3'(data_width / 8 - 1) & ~3'(nbytes - 4'd1);
        m      = ((16'(1) << nbytes) - 16'd1) << off;
        return m[7:0];
    endfunction

endpackage

// File: rtl/ahbl_sram_mem.sv
// Single-port byte-enabled synchronous RAM with registered, enable-gated read port.
module ahbl_sram_mem #(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned DEPTH      = 1024,
    localparam int unsigned NB         = DATA_WIDTH / 8,
    localparam int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [NB-1:0]         wr_be,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NB); i++) begin
            if (wr_be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
    end

    // Read register only moves on a read, so it doubles as the HRDATA hold stage.
    always_ff @(posedge clk) begin
        if (rst)        rdata <= '0;
        else if (rd_en) rdata <= mem[addr];
    end

endmodule

// File: rtl/ahbl_sram_wide.sv
// AHB-Lite memory slave: FSM, wait counter, delayed-write buffer and read forwarding.
module ahbl_sram_wide
    import ahbl_sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned ADDR_WIDTH  = 20,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic                  HREADYIN,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HBURST,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP
);

    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned LB = $clog2(NB);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 2;

    state_t                state;
    logic [CW-1:0]         wcnt;
    logic                  ready_q;
    logic [1:0]            resp_q;

    logic [AW-1:0]         wb_addr;
    logic [NB-1:0]         wb_lanes;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_wait;
    logic                  wb_full;

    logic [DATA_WIDTH-1:0] fwd_data;
    logic [NB-1:0]         fwd_lanes;

    logic                  active, xfer_err, rd_go, wr_go;
    logic                  dp_wr_done, commit_buf, commit_hw;
    logic [AW-1:0]         a_idx;
    logic [7:0]            mask8;
    logic [NB-1:0]         a_lanes;
    logic [AW-1:0]         ram_addr;
    logic [NB-1:0]         ram_be;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_q;
    logic                  unused;

    assign unused = ^{HBURST, HTRANS[0], mask8};

    // Address-phase decode and write-buffer commit arbitration for the single RAM port.
    always_comb begin
        active     = HSEL & HREADYIN & HTRANS[1] & ready_q;
        xfer_err   = (HSIZE > 3'(LB)) | (|HADDR[ADDR_WIDTH-1:LB+AW]);
        rd_go      = active & ~xfer_err & ~HWRITE;
        wr_go      = active & ~xfer_err & HWRITE;
        a_idx      = HADDR[LB +: AW];
        mask8      = lane_mask(HSIZE, HADDR[2:0], DATA_WIDTH);
        a_lanes    = mask8[NB-1:0];
        dp_wr_done = wb_wait & ready_q;
        commit_buf = wb_full & ~rd_go & ~HRESET;
        commit_hw  = dp_wr_done & wr_go & ~HRESET;

        ram_addr  = a_idx;
        ram_be    = '0;
        ram_wdata = wb_data;
        if (commit_buf) begin
            ram_addr = wb_addr;
            ram_be   = wb_lanes;
        end else if (commit_hw) begin
            ram_addr  = wb_addr;
            ram_be    = wb_lanes;
            ram_wdata = HWDATA;
        end
    end

    ahbl_sram_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (HCLK),
        .rst   (HRESET),
        .rd_en (rd_go),
        .wr_be (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    // Response FSM; IDLE, ERR2 and the final WAIT cycle all accept a new address phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= ST_IDLE;
            wcnt    <= '0;
            ready_q <= 1'b1;
            resp_q  <= HRESP_OKAY;
        end else if (state == ST_ERR1) begin
            state   <= ST_ERR2;
            ready_q <= 1'b1;
            resp_q  <= HRESP_ERROR;
        end else if (state == ST_WAIT && wcnt != '0) begin
            wcnt    <= wcnt - CW'(1);
            ready_q <= (wcnt == CW'(1));
        end else if (active && xfer_err) begin
            state   <= ST_ERR1;
            ready_q <= 1'b0;
            resp_q  <= HRESP_ERROR;
        end else if (active && WAIT_STATES != 0) begin
            state   <= ST_WAIT;
            wcnt    <= CW'(WAIT_STATES);
            ready_q <= 1'b0;
            resp_q  <= HRESP_OKAY;
        end else begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            resp_q  <= HRESP_OKAY;
        end
    end

    // Write buffer: address at the address phase, data when the data phase completes.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wb_addr  <= '0;
            wb_lanes <= '0;
            wb_data  <= '0;
            wb_wait  <= 1'b0;
            wb_full  <= 1'b0;
        end else begin
            if (commit_buf) wb_full <= 1'b0;
            if (dp_wr_done) begin
                wb_wait <= 1'b0;
                if (!commit_hw) begin
                    wb_full <= 1'b1;
                    wb_data <= HWDATA;
                end
            end
            if (wr_go) begin
                wb_addr  <= a_idx;
                wb_lanes <= a_lanes;
                wb_wait  <= 1'b1;
            end
        end
    end

    // Forwarding snapshot taken with the read address; a completing write uses live HWDATA.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            fwd_data  <= '0;
            fwd_lanes <= '0;
        end else if (rd_go) begin
            if (wb_full && wb_addr == a_idx) begin
                fwd_data  <= wb_data;
                fwd_lanes <= wb_lanes;
            end else if (dp_wr_done && wb_addr == a_idx) begin
                fwd_data  <= HWDATA;
                fwd_lanes <= wb_lanes;
            end else begin
                fwd_lanes <= '0;
            end
        end
    end

    always_comb begin
        HRDATA = ram_q;
        for (int i = 0; i < int'(NB); i++) begin
            if (fwd_lanes[i]) HRDATA[i*8 +: 8] = fwd_data[i*8 +: 8];
        end
    end

    assign HREADYOUT = ready_q;
    assign HRESP     = resp_q;

endmodule
